// File: rtl/axi_slave_demux_r.sv
// AXI read-channel demux: decodes ARADDR to one of four slaves, forwards AR, routes the R burst back.
// Latency: AR handshake no earlier than 1 cycle after ARVALID is seen in IDLE; R beats pass through combinationally.
// Backpressure: ARREADY follows the selected slave's ARREADY; the selected slave's RREADY follows s2m_RREADY; DECERR beats wait on s2m_RREADY.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s2m_AR*/ARVALID/ARREADY   read address from the master-side mux
//   s2m_R*/RVALID/RREADY      read data back to the master-side mux
//   mN_AR*/ARVALID/ARREADY    read address to slave N (payload broadcast, only ARVALID gated)
//   mN_R*/RVALID/RREADY       read data from slave N
module axi_slave_demux_r #(
   parameter int                    DATA_WIDTH = 1024,
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    ID_WIDTH   = 8,
   parameter int                    USER_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] SLV0_BASE  = 64'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV1_BASE  = 64'h1000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV2_BASE  = 64'h2000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV3_BASE  = 64'h3000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV0_MASK  = 64'hF000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV1_MASK  = 64'hF000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV2_MASK  = 64'hF000_0000,
   parameter logic [ADDR_WIDTH-1:0] SLV3_MASK  = 64'hF000_0000
) (
   input  logic                  clk,
   input  logic                  rstn,
   // master side AR
   input  logic [ID_WIDTH-1:0]   s2m_ARID,
   input  logic [ADDR_WIDTH-1:0] s2m_ARADDR,
   input  logic [7:0]            s2m_ARLEN,
   input  logic [2:0]            s2m_ARSIZE,
   input  logic [1:0]            s2m_ARBURST,
   input  logic                  s2m_ARLOCK,
   input  logic [3:0]            s2m_ARCACHE,
   input  logic [2:0]            s2m_ARPROT,
   input  logic [3:0]            s2m_ARQOS,
   input  logic [3:0]            s2m_ARREGION,
   input  logic [USER_WIDTH-1:0] s2m_ARUSER,
   input  logic                  s2m_ARVALID,
   output logic                  s2m_ARREADY,
   // master side R
   output logic                  s2m_RVALID,
   input  logic                  s2m_RREADY,
   output logic [ID_WIDTH-1:0]   s2m_RID,
   output logic [DATA_WIDTH-1:0] s2m_RDATA,
   output logic [1:0]            s2m_RRESP,
   output logic                  s2m_RLAST,
   output logic [USER_WIDTH-1:0] s2m_RUSER,
   // slave 0
   output logic [ID_WIDTH-1:0]   m0_ARID,
   output logic [ADDR_WIDTH-1:0] m0_ARADDR,
   output logic [7:0]            m0_ARLEN,
   output logic [2:0]            m0_ARSIZE,
   output logic [1:0]            m0_ARBURST,
   output logic                  m0_ARLOCK,
   output logic [3:0]            m0_ARCACHE,
   output logic [2:0]            m0_ARPROT,
   output logic [3:0]            m0_ARQOS,
   output logic [3:0]            m0_ARREGION,
   output logic [USER_WIDTH-1:0] m0_ARUSER,
   output logic                  m0_ARVALID,
   input  logic                  m0_ARREADY,
   input  logic                  m0_RVALID,
   output logic                  m0_RREADY,
   input  logic [ID_WIDTH-1:0]   m0_RID,
   input  logic [DATA_WIDTH-1:0] m0_RDATA,
   input  logic [1:0]            m0_RRESP,
   input  logic                  m0_RLAST,
   input  logic [USER_WIDTH-1:0] m0_RUSER,
   // slave 1
   output logic [ID_WIDTH-1:0]   m1_ARID,
   output logic [ADDR_WIDTH-1:0] m1_ARADDR,
   output logic [7:0]            m1_ARLEN,
   output logic [2:0]            m1_ARSIZE,
   output logic [1:0]            m1_ARBURST,
   output logic                  m1_ARLOCK,
   output logic [3:0]            m1_ARCACHE,
   output logic [2:0]            m1_ARPROT,
   output logic [3:0]            m1_ARQOS,
   output logic [3:0]            m1_ARREGION,
   output logic [USER_WIDTH-1:0] m1_ARUSER,
   output logic                  m1_ARVALID,
   input  logic                  m1_ARREADY,
   input  logic                  m1_RVALID,
   output logic                  m1_RREADY,
   input  logic [ID_WIDTH-1:0]   m1_RID,
   input  logic [DATA_WIDTH-1:0] m1_RDATA,
   input  logic [1:0]            m1_RRESP,
   input  logic                  m1_RLAST,
   input  logic [USER_WIDTH-1:0] m1_RUSER,
   // slave 2
   output logic [ID_WIDTH-1:0]   m2_ARID,
   output logic [ADDR_WIDTH-1:0] m2_ARADDR,
   output logic [7:0]            m2_ARLEN,
   output logic [2:0]            m2_ARSIZE,
   output logic [1:0]            m2_ARBURST,
   output logic                  m2_ARLOCK,
   output logic [3:0]            m2_ARCACHE,
   output logic [2:0]            m2_ARPROT,
   output logic [3:0]            m2_ARQOS,
   output logic [3:0]            m2_ARREGION,
   output logic [USER_WIDTH-1:0] m2_ARUSER,
   output logic                  m2_ARVALID,
   input  logic                  m2_ARREADY,
   input  logic                  m2_RVALID,
   output logic                  m2_RREADY,
   input  logic [ID_WIDTH-1:0]   m2_RID,
   input  logic [DATA_WIDTH-1:0] m2_RDATA,
   input  logic [1:0]            m2_RRESP,
   input  logic                  m2_RLAST,
   input  logic [USER_WIDTH-1:0] m2_RUSER,
   // slave 3
   output logic [ID_WIDTH-1:0]   m3_ARID,
   output logic [ADDR_WIDTH-1:0] m3_ARADDR,
   output logic [7:0]            m3_ARLEN,
   output logic [2:0]            m3_ARSIZE,
   output logic [1:0]            m3_ARBURST,
   output logic                  m3_ARLOCK,
   output logic [3:0]            m3_ARCACHE,
   output logic [2:0]            m3_ARPROT,
   output logic [3:0]            m3_ARQOS,
   output logic [3:0]            m3_ARREGION,
   output logic [USER_WIDTH-1:0] m3_ARUSER,
   output logic                  m3_ARVALID,
   input  logic                  m3_ARREADY,
   input  logic                  m3_RVALID,
   output logic                  m3_RREADY,
   input  logic [ID_WIDTH-1:0]   m3_RID,
   input  logic [DATA_WIDTH-1:0] m3_RDATA,
   input  logic [1:0]            m3_RRESP,
   input  logic                  m3_RLAST,
   input  logic [USER_WIDTH-1:0] m3_RUSER
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DERR = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE [4] = '{SLV0_BASE, SLV1_BASE, SLV2_BASE, SLV3_BASE};
   localparam logic [ADDR_WIDTH-1:0] MASK [4] = '{SLV0_MASK, SLV1_MASK, SLV2_MASK, SLV3_MASK};

   // ------------------------------------------------------------------
   // AR payload broadcast: every slave sees the payload, only ARVALID is steered
   // ------------------------------------------------------------------
   assign m0_ARID     = s2m_ARID;     assign m1_ARID     = s2m_ARID;
   assign m2_ARID     = s2m_ARID;     assign m3_ARID     = s2m_ARID;
   assign m0_ARADDR   = s2m_ARADDR;   assign m1_ARADDR   = s2m_ARADDR;
   assign m2_ARADDR   = s2m_ARADDR;   assign m3_ARADDR   = s2m_ARADDR;
   assign m0_ARLEN    = s2m_ARLEN;    assign m1_ARLEN    = s2m_ARLEN;
   assign m2_ARLEN    = s2m_ARLEN;    assign m3_ARLEN    = s2m_ARLEN;
   assign m0_ARSIZE   = s2m_ARSIZE;   assign m1_ARSIZE   = s2m_ARSIZE;
   assign m2_ARSIZE   = s2m_ARSIZE;   assign m3_ARSIZE   = s2m_ARSIZE;
   assign m0_ARBURST  = s2m_ARBURST;  assign m1_ARBURST  = s2m_ARBURST;
   assign m2_ARBURST  = s2m_ARBURST;  assign m3_ARBURST  = s2m_ARBURST;
   assign m0_ARLOCK   = s2m_ARLOCK;   assign m1_ARLOCK   = s2m_ARLOCK;
   assign m2_ARLOCK   = s2m_ARLOCK;   assign m3_ARLOCK   = s2m_ARLOCK;
   assign m0_ARCACHE  = s2m_ARCACHE;  assign m1_ARCACHE  = s2m_ARCACHE;
   assign m2_ARCACHE  = s2m_ARCACHE;  assign m3_ARCACHE  = s2m_ARCACHE;
   assign m0_ARPROT   = s2m_ARPROT;   assign m1_ARPROT   = s2m_ARPROT;
   assign m2_ARPROT   = s2m_ARPROT;   assign m3_ARPROT   = s2m_ARPROT;
   assign m0_ARQOS    = s2m_ARQOS;    assign m1_ARQOS    = s2m_ARQOS;
   assign m2_ARQOS    = s2m_ARQOS;    assign m3_ARQOS    = s2m_ARQOS;
   assign m0_ARREGION = s2m_ARREGION; assign m1_ARREGION = s2m_ARREGION;
   assign m2_ARREGION = s2m_ARREGION; assign m3_ARREGION = s2m_ARREGION;
   assign m0_ARUSER   = s2m_ARUSER;   assign m1_ARUSER   = s2m_ARUSER;
   assign m2_ARUSER   = s2m_ARUSER;   assign m3_ARUSER   = s2m_ARUSER;

   // ------------------------------------------------------------------
   // Gather the per-slave handshake/return signals into indexable form
   // ------------------------------------------------------------------
   logic [3:0]            m_arready;
   logic [3:0]            m_arvalid;
   logic [3:0]            m_rvalid;
   logic [3:0]            m_rready;
   logic [3:0]            m_rlast;
   logic [ID_WIDTH-1:0]   m_rid   [4];
   logic [DATA_WIDTH-1:0] m_rdata [4];
   logic [1:0]            m_rresp [4];
   logic [USER_WIDTH-1:0] m_ruser [4];

   assign m_arready = {m3_ARREADY, m2_ARREADY, m1_ARREADY, m0_ARREADY};
   assign m_rvalid  = {m3_RVALID,  m2_RVALID,  m1_RVALID,  m0_RVALID};
   assign m_rlast   = {m3_RLAST,   m2_RLAST,   m1_RLAST,   m0_RLAST};
   assign m_rid[0]   = m0_RID;   assign m_rid[1]   = m1_RID;
   assign m_rid[2]   = m2_RID;   assign m_rid[3]   = m3_RID;
   assign m_rdata[0] = m0_RDATA; assign m_rdata[1] = m1_RDATA;
   assign m_rdata[2] = m2_RDATA; assign m_rdata[3] = m3_RDATA;
   assign m_rresp[0] = m0_RRESP; assign m_rresp[1] = m1_RRESP;
   assign m_rresp[2] = m2_RRESP; assign m_rresp[3] = m3_RRESP;
   assign m_ruser[0] = m0_RUSER; assign m_ruser[1] = m1_RUSER;
   assign m_ruser[2] = m2_RUSER; assign m_ruser[3] = m3_RUSER;

   assign {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID} = m_arvalid;
   assign {m3_RREADY,  m2_RREADY,  m1_RREADY,  m0_RREADY}  = m_rready;

   // ------------------------------------------------------------------
   // Address decode: lowest-index matching window wins
   // ------------------------------------------------------------------
   logic       dec_hit;
   logic [1:0] dec_sel;

   always_comb begin
      dec_hit = 1'b0;
      dec_sel = 2'd0;
      // Walk downwards so the lowest matching index is the one left standing.
      for (int i = 3; i >= 0; i--) begin
         if ((s2m_ARADDR & MASK[i]) == BASE[i]) begin
            dec_hit = 1'b1;
            dec_sel = 2'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Transaction state
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic                miss_q, miss_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [7:0]          len_q, len_d;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      miss_d  = miss_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            // Decode is captured here, so sel/ID/len are frozen before any
            // slave sees ARVALID.
            if (s2m_ARVALID) begin
               sel_d   = dec_sel;
               miss_d  = ~dec_hit;
               id_d    = s2m_ARID;
               len_d   = s2m_ARLEN;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (s2m_ARVALID && s2m_ARREADY) begin
               state_d = miss_q ? ST_DERR : ST_DATA;
            end
         end
         ST_DATA: begin
            if (s2m_RVALID && s2m_RREADY && s2m_RLAST) begin
               state_d = ST_IDLE;
            end
         end
         ST_DERR: begin
            // RVALID is constant 1 here, so RREADY alone is the handshake.
            if (s2m_RREADY) begin
               if (cnt_q == len_q) begin
                  cnt_d   = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         miss_q  <= 1'b0;
         cnt_q   <= 8'd0;
         id_q    <= '0;
         len_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         miss_q  <= miss_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         len_q   <= len_d;
      end
   end

   // ------------------------------------------------------------------
   // Handshake steering and R return mux
   // ------------------------------------------------------------------
   always_comb begin
      m_arvalid   = 4'b0000;
      m_rready    = 4'b0000;
      s2m_ARREADY = 1'b0;
      s2m_RVALID  = 1'b0;
      s2m_RID     = '0;
      s2m_RDATA   = '0;
      s2m_RRESP   = 2'b00;
      s2m_RLAST   = 1'b0;
      s2m_RUSER   = '0;
      case (state_q)
         ST_ADDR: begin
            if (miss_q) begin
               s2m_ARREADY = 1'b1;
            end else begin
               m_arvalid[sel_q] = s2m_ARVALID;
               s2m_ARREADY      = m_arready[sel_q];
            end
         end
         ST_DATA: begin
            s2m_RVALID      = m_rvalid[sel_q];
            s2m_RID         = m_rid[sel_q];
            s2m_RDATA       = m_rdata[sel_q];
            s2m_RRESP       = m_rresp[sel_q];
            s2m_RLAST       = m_rlast[sel_q];
            s2m_RUSER       = m_ruser[sel_q];
            m_rready[sel_q] = s2m_RREADY;
         end
         ST_DERR: begin
            s2m_RVALID = 1'b1;
            s2m_RID    = id_q;
            s2m_RRESP  = 2'b11;
            s2m_RLAST  = (cnt_q == len_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_slave_demux_r.sv
module tb_axi_slave_demux_r;

   typedef struct {
      logic [7:0]    id;
      logic [1023:0] data;
      logic [1:0]    resp;
      logic [7:0]    user;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // master-side stimulus
   logic [7:0]    s2m_ARID;
   logic [63:0]   s2m_ARADDR;
   logic [7:0]    s2m_ARLEN;
   logic [2:0]    s2m_ARSIZE;
   logic [1:0]    s2m_ARBURST;
   logic          s2m_ARLOCK;
   logic [3:0]    s2m_ARCACHE;
   logic [2:0]    s2m_ARPROT;
   logic [3:0]    s2m_ARQOS;
   logic [3:0]    s2m_ARREGION;
   logic [7:0]    s2m_ARUSER;
   logic          s2m_ARVALID;
   logic          s2m_ARREADY;
   logic          s2m_RVALID;
   logic          s2m_RREADY;
   logic [7:0]    s2m_RID;
   logic [1023:0] s2m_RDATA;
   logic [1:0]    s2m_RRESP;
   logic          s2m_RLAST;
   logic [7:0]    s2m_RUSER;

   // slave-side observed outputs
   logic [7:0]  o_arid     [4];
   logic [63:0] o_araddr   [4];
   logic [7:0]  o_arlen    [4];
   logic [2:0]  o_arsize   [4];
   logic [1:0]  o_arburst  [4];
   logic        o_arlock   [4];
   logic [3:0]  o_arcache  [4];
   logic [2:0]  o_arprot   [4];
   logic [3:0]  o_arqos    [4];
   logic [3:0]  o_arregion [4];
   logic [7:0]  o_aruser   [4];
   logic [3:0]  o_arvalid;
   logic [3:0]  o_rready;

   // slave models' driven inputs
   logic          s_arready [4];
   logic          s_rvalid  [4];
   logic [7:0]    s_rid     [4];
   logic [1023:0] s_rdata   [4];
   logic [1:0]    s_rresp   [4];
   logic          s_rlast   [4];
   logic [7:0]    s_ruser   [4];

   axi_slave_demux_r dut (
      .clk(clk), .rstn(rstn),
      .s2m_ARID(s2m_ARID), .s2m_ARADDR(s2m_ARADDR), .s2m_ARLEN(s2m_ARLEN), .s2m_ARSIZE(s2m_ARSIZE),
      .s2m_ARBURST(s2m_ARBURST), .s2m_ARLOCK(s2m_ARLOCK), .s2m_ARCACHE(s2m_ARCACHE), .s2m_ARPROT(s2m_ARPROT),
      .s2m_ARQOS(s2m_ARQOS), .s2m_ARREGION(s2m_ARREGION), .s2m_ARUSER(s2m_ARUSER),
      .s2m_ARVALID(s2m_ARVALID), .s2m_ARREADY(s2m_ARREADY),
      .s2m_RVALID(s2m_RVALID), .s2m_RREADY(s2m_RREADY), .s2m_RID(s2m_RID), .s2m_RDATA(s2m_RDATA),
      .s2m_RRESP(s2m_RRESP), .s2m_RLAST(s2m_RLAST), .s2m_RUSER(s2m_RUSER),
      .m0_ARID(o_arid[0]), .m0_ARADDR(o_araddr[0]), .m0_ARLEN(o_arlen[0]), .m0_ARSIZE(o_arsize[0]),
      .m0_ARBURST(o_arburst[0]), .m0_ARLOCK(o_arlock[0]), .m0_ARCACHE(o_arcache[0]), .m0_ARPROT(o_arprot[0]),
      .m0_ARQOS(o_arqos[0]), .m0_ARREGION(o_arregion[0]), .m0_ARUSER(o_aruser[0]),
      .m0_ARVALID(o_arvalid[0]), .m0_ARREADY(s_arready[0]), .m0_RVALID(s_rvalid[0]), .m0_RREADY(o_rready[0]),
      .m0_RID(s_rid[0]), .m0_RDATA(s_rdata[0]), .m0_RRESP(s_rresp[0]), .m0_RLAST(s_rlast[0]), .m0_RUSER(s_ruser[0]),
      .m1_ARID(o_arid[1]), .m1_ARADDR(o_araddr[1]), .m1_ARLEN(o_arlen[1]), .m1_ARSIZE(o_arsize[1]),
      .m1_ARBURST(o_arburst[1]), .m1_ARLOCK(o_arlock[1]), .m1_ARCACHE(o_arcache[1]), .m1_ARPROT(o_arprot[1]),
      .m1_ARQOS(o_arqos[1]), .m1_ARREGION(o_arregion[1]), .m1_ARUSER(o_aruser[1]),
      .m1_ARVALID(o_arvalid[1]), .m1_ARREADY(s_arready[1]), .m1_RVALID(s_rvalid[1]), .m1_RREADY(o_rready[1]),
      .m1_RID(s_rid[1]), .m1_RDATA(s_rdata[1]), .m1_RRESP(s_rresp[1]), .m1_RLAST(s_rlast[1]), .m1_RUSER(s_ruser[1]),
      .m2_ARID(o_arid[2]), .m2_ARADDR(o_araddr[2]), .m2_ARLEN(o_arlen[2]), .m2_ARSIZE(o_arsize[2]),
      .m2_ARBURST(o_arburst[2]), .m2_ARLOCK(o_arlock[2]), .m2_ARCACHE(o_arcache[2]), .m2_ARPROT(o_arprot[2]),
      .m2_ARQOS(o_arqos[2]), .m2_ARREGION(o_arregion[2]), .m2_ARUSER(o_aruser[2]),
      .m2_ARVALID(o_arvalid[2]), .m2_ARREADY(s_arready[2]), .m2_RVALID(s_rvalid[2]), .m2_RREADY(o_rready[2]),
      .m2_RID(s_rid[2]), .m2_RDATA(s_rdata[2]), .m2_RRESP(s_rresp[2]), .m2_RLAST(s_rlast[2]), .m2_RUSER(s_ruser[2]),
      .m3_ARID(o_arid[3]), .m3_ARADDR(o_araddr[3]), .m3_ARLEN(o_arlen[3]), .m3_ARSIZE(o_arsize[3]),
      .m3_ARBURST(o_arburst[3]), .m3_ARLOCK(o_arlock[3]), .m3_ARCACHE(o_arcache[3]), .m3_ARPROT(o_arprot[3]),
      .m3_ARQOS(o_arqos[3]), .m3_ARREGION(o_arregion[3]), .m3_ARUSER(o_aruser[3]),
      .m3_ARVALID(o_arvalid[3]), .m3_ARREADY(s_arready[3]), .m3_RVALID(s_rvalid[3]), .m3_RREADY(o_rready[3]),
      .m3_RID(s_rid[3]), .m3_RDATA(s_rdata[3]), .m3_RRESP(s_rresp[3]), .m3_RLAST(s_rlast[3]), .m3_RUSER(s_ruser[3])
   );

   // ---------------- shared bench state ----------------
   int    compared = 0;
   int    failed   = 0;
   beat_t exp_q [$];       // expected s2m R beats, in order
   beat_t sl_q  [4][$];    // beats each slave model will return
   bit    act   [4];       // slave model holds an accepted AR and owes beats
   bit    in_ar = 1'b0;    // AR of the current transaction not yet accepted
   int    ar_age = 0;      // cycles ARVALID has been held so far
   int    cur_tgt = 5;     // 0..3 slave, 4 unmapped, 5 none

   task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
      compared++;
      if (act_v !== exp_v) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act_v, exp_v, $time);
      end
   endtask

   task automatic chk_data(input string nm, input logic [1023:0] act_v, input logic [1023:0] exp_v);
      compared++;
      if (act_v !== exp_v) begin
         failed++;
         $display("FAIL %s: got low64 %0h, expected low64 %0h (t=%0t)", nm, act_v[63:0], exp_v[63:0], $time);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   endtask

   // Reference decode: bits [31:28] select the 256MB window; windows 0..3 are slaves.
   function automatic int model_tgt(input logic [63:0] a);
      int top;
      top = int'(a[31:28]);
      return (top < 4) ? top : 4;
   endfunction

   function automatic logic [1023:0] rand_data();
      logic [1023:0] d;
      for (int k = 0; k < 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // ---------------- slave models ----------------
   initial begin : slaves
      bit    arhs [4];
      bit    rhs  [4];
      bit    pres [4];
      beat_t b;
      for (int g = 0; g < 4; g++) begin
         s_arready[g] = 1'b0; s_rvalid[g] = 1'b0; s_rid[g] = '0; s_rdata[g] = '0;
         s_rresp[g] = '0; s_rlast[g] = 1'b0; s_ruser[g] = '0; act[g] = 1'b0; pres[g] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 4; g++) begin
            arhs[g] = o_arvalid[g] && s_arready[g];
            rhs[g]  = s_rvalid[g] && o_rready[g];
         end
         @(posedge clk);
         #1;
         for (int g = 0; g < 4; g++) begin
            if (!rstn) begin
               act[g] = 1'b0; pres[g] = 1'b0; s_rvalid[g] = 1'b0; s_arready[g] = 1'b0;
               sl_q[g].delete();
               continue;
            end
            if (rhs[g] && pres[g]) begin
               b = sl_q[g].pop_front();
               pres[g] = 1'b0;
               if (b.last) act[g] = 1'b0;
            end
            if (arhs[g]) act[g] = 1'b1;
            s_arready[g] = ($urandom_range(0, 1) == 1);
            if (!pres[g]) begin
               if (act[g] && sl_q[g].size() > 0 && $urandom_range(0, 3) != 0) begin
                  b = sl_q[g][0];
                  pres[g] = 1'b1;
                  s_rvalid[g] = 1'b1; s_rid[g] = b.id; s_rdata[g] = b.data;
                  s_rresp[g] = b.resp; s_rlast[g] = b.last; s_ruser[g] = b.user;
               end else begin
                  // Idle slaves occasionally raise a stray RVALID with junk payload.
                  s_rvalid[g] = !act[g] && ($urandom_range(0, 7) == 0);
                  s_rid[g] = 8'($urandom); s_rdata[g] = rand_data(); s_rresp[g] = 2'($urandom);
                  s_rlast[g] = 1'($urandom); s_ruser[g] = 8'($urandom);
               end
            end
         end
      end
   end

   // ---------------- master RREADY ----------------
   initial begin : rready_drv
      s2m_RREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         s2m_RREADY = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic  exp_rdy;
      beat_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            exp_rdy = 1'b0;
            if (in_ar && ar_age >= 1 && s2m_ARVALID)
               exp_rdy = (cur_tgt == 4) ? 1'b1 : s_arready[cur_tgt];
            chk("s2m_arready", 64'(s2m_ARREADY), 64'(exp_rdy));
            for (int g = 0; g < 4; g++) begin
               chk($sformatf("m%0d_arvalid", g), 64'(o_arvalid[g]),
                   64'(in_ar && ar_age >= 1 && s2m_ARVALID && cur_tgt == g));
               chk($sformatf("m%0d_rready", g), 64'(o_rready[g]), 64'(act[g] && s2m_RREADY));
               if (in_ar) begin
                  chk($sformatf("m%0d_araddr", g), o_araddr[g], s2m_ARADDR);
                  chk($sformatf("m%0d_ar_misc", g),
                      64'({o_arid[g], o_arlen[g], o_arsize[g], o_arburst[g], o_arlock[g], o_arcache[g],
                           o_arprot[g], o_arqos[g], o_arregion[g], o_aruser[g]}),
                      64'({s2m_ARID, s2m_ARLEN, s2m_ARSIZE, s2m_ARBURST, s2m_ARLOCK, s2m_ARCACHE,
                           s2m_ARPROT, s2m_ARQOS, s2m_ARREGION, s2m_ARUSER}));
               end
            end
            if (exp_q.size() == 0 || in_ar) begin
               chk("idle_rvalid", 64'(s2m_RVALID), 64'd0);
               chk("idle_rpayload", 64'({s2m_RID, s2m_RRESP, s2m_RLAST, s2m_RUSER}), 64'd0);
               chk_data("idle_rdata", s2m_RDATA, '0);
            end else begin
               if (cur_tgt == 4) chk("derr_rvalid", 64'(s2m_RVALID), 64'd1);
               if (s2m_RVALID && s2m_RREADY) begin
                  e = exp_q.pop_front();
                  chk("rid", 64'(s2m_RID), 64'(e.id));
                  chk("rresp", 64'(s2m_RRESP), 64'(e.resp));
                  chk("rlast", 64'(s2m_RLAST), 64'(e.last));
                  chk("ruser", 64'(s2m_RUSER), 64'(e.user));
                  chk_data("rdata", s2m_RDATA, e.data);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 3000) begin
            failed++;
            $display("FAIL burst_timeout: %0d beats still owed after %0d cycles", exp_q.size(), n);
            finish_run();
         end
      end
   endtask

   task automatic issue(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
      int    tgt;
      int    n;
      bit    hs;
      beat_t b;
      wait_idle();
      tgt = model_tgt(addr);
      in_ar = 1'b1;
      cur_tgt = tgt;
      for (int i = 0; i <= int'(len); i++) begin
         b.id   = id;
         b.last = (i == int'(len));
         if (tgt < 4) begin
            b.data = rand_data();
            b.resp = 2'($urandom_range(0, 1));
            b.user = 8'($urandom);
            sl_q[tgt].push_back(b);
         end else begin
            b.data = '0;
            b.resp = 2'b11;
            b.user = 8'h00;
         end
         exp_q.push_back(b);
      end
      s2m_ARADDR = addr; s2m_ARLEN = len; s2m_ARID = id;
      s2m_ARSIZE = 3'($urandom); s2m_ARBURST = 2'($urandom); s2m_ARLOCK = 1'($urandom);
      s2m_ARCACHE = 4'($urandom); s2m_ARPROT = 3'($urandom); s2m_ARQOS = 4'($urandom);
      s2m_ARREGION = 4'($urandom); s2m_ARUSER = 8'($urandom);
      s2m_ARVALID = 1'b1;
      ar_age = 0;
      n = 0;
      hs = 1'b0;
      while (!hs) begin
         @(negedge clk);
         hs = s2m_ARREADY;
         @(posedge clk);
         #1;
         ar_age++;
         n++;
         if (!hs && n > 200) begin
            failed++;
            $display("FAIL ar_timeout: no ARREADY after %0d cycles, addr %0h", n, addr);
            finish_run();
         end
      end
      s2m_ARVALID = 1'b0;
      in_ar = 1'b0;
   endtask

   initial begin : main
      int n;
      rstn = 1'b0;
      s2m_ARVALID = 1'b0;
      s2m_ARID = 8'h3C; s2m_ARADDR = 64'h1234_5678_9ABC_DEF0; s2m_ARLEN = 8'h11;
      s2m_ARSIZE = 3'd0; s2m_ARBURST = 2'd0; s2m_ARLOCK = 1'b0; s2m_ARCACHE = 4'd0;
      s2m_ARPROT = 3'd0; s2m_ARQOS = 4'd0; s2m_ARREGION = 4'd0; s2m_ARUSER = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", 64'(s2m_ARREADY), 64'd0);
      chk("rst_rvalid", 64'(s2m_RVALID), 64'd0);
      chk("rst_rpayload", 64'({s2m_RID, s2m_RRESP, s2m_RLAST, s2m_RUSER}), 64'd0);
      chk_data("rst_rdata", s2m_RDATA, '0);
      chk("rst_m_arvalid", 64'(o_arvalid), 64'd0);
      chk("rst_m_rready", 64'(o_rready), 64'd0);
      chk("rst_m2_araddr", o_araddr[2], 64'h1234_5678_9ABC_DEF0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // directed cases
      issue(64'h0000_0000_1000_0040, 8'd3,   8'h05);
      issue(64'h0000_0000_8000_0000, 8'd2,   8'hA5);
      issue(64'h0000_0000_2000_0100, 8'd0,   8'h11);
      issue(64'h0000_0000_F000_0000, 8'd255, 8'h42);
      issue(64'h0000_0000_0000_0010, 8'd5,   8'h99);
      issue(64'hFFFF_0000_3FFF_FFFC, 8'd1,   8'h07);

      // reset in the middle of a 4-beat burst to slave 0
      issue(64'h0000_0000_0000_0200, 8'd3, 8'h33);
      n = 0;
      while (exp_q.size() > 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_beats_left", 64'(exp_q.size()), 64'd2);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("midrst_arready", 64'(s2m_ARREADY), 64'd0);
      chk("midrst_rvalid", 64'(s2m_RVALID), 64'd0);
      chk("midrst_rlast", 64'(s2m_RLAST), 64'd0);
      chk("midrst_m_arvalid", 64'(o_arvalid), 64'd0);
      chk("midrst_m_rready", 64'(o_rready), 64'd0);
      exp_q.delete();
      cur_tgt = 5;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      issue(64'h0000_0000_3000_0000, 8'd3, 8'h77);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         logic [63:0] a;
         logic [7:0]  l;
         a = {$urandom, $urandom};
         a[31:28] = 4'($urandom_range(0, 5));
         l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 7));
         issue(a, l, 8'($urandom));
      end

      wait_idle();
      repeat (4) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++)
         chk($sformatf("slave%0d_unconsumed", g), 64'(sl_q[g].size()), 64'd0);
      finish_run();
   end

   initial begin : watchdog
      #600000;
      failed++;
      $display("FAIL watchdog: simulation did not complete in time");
      finish_run();
   end

endmodule
